// File: rtl/hamming_secded_encoder.sv
`default_nettype none
// ============================================================================
// hamming_secded_encoder : sequential SECDED (16,11) encoder, byte-wide memory
// Revision 1.0
// ============================================================================
module hamming_secded_encoder #(
  parameter int W        = 8,
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  output logic         Done,
  output logic [9:0]   mem_addr,
  output logic         mem_rd_en,
  input  logic [W-1:0] mem_rd_data,
  output logic         mem_wr_en,
  output logic [W-1:0] mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CALC  = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] c_LAST_MSG = 8'(NUM_MSG - 1);
  localparam logic [9:0] c_SRC_BASE = 10'(SRC_BASE);
  localparam logic [9:0] c_DST_BASE = 10'(DST_BASE);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_cnt;
  logic [7:0]   r_lo;
  logic [7:0]   r_cw_lo;
  logic [7:0]   r_cw_hi;

  logic [9:0]   w_msg_off;
  logic [10:0]  w_d;
  logic         w_p1;
  logic         w_p2;
  logic         w_p4;
  logic         w_p8;
  logic         w_p0;
  logic         w_unused_hi;

  assign w_msg_off = {1'b0, r_cnt, 1'b0};

  // Data bits b1..b11 map to w_d[0]..w_d[10]; hi[7:3] carry no payload.
  assign w_d         = {mem_rd_data[2:0], r_lo};
  assign w_unused_hi = ^mem_rd_data[W-1:3];

  assign w_p1 = w_d[10] ^ w_d[8] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1] ^ w_d[0];
  assign w_p2 = w_d[10] ^ w_d[9] ^ w_d[6] ^ w_d[5] ^ w_d[3] ^ w_d[2] ^ w_d[0];
  assign w_p4 = w_d[10] ^ w_d[9] ^ w_d[8] ^ w_d[7] ^ w_d[3] ^ w_d[2] ^ w_d[1];
  assign w_p8 = ^w_d[10:4];
  assign w_p0 = (^w_d) ^ w_p1 ^ w_p2 ^ w_p4 ^ w_p8;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= 8'd0;
      r_lo    <= 8'd0;
      r_cw_lo <= 8'd0;
      r_cw_hi <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt <= 8'd0;
          end
        end
        S_RD_HI: begin
          r_lo <= mem_rd_data[7:0];
        end
        S_CALC: begin
          r_cw_lo <= {w_d[3], w_d[2], w_d[1], w_p4, w_d[0], w_p2, w_p1, w_p0};
          r_cw_hi <= {w_d[10:4], w_p8};
        end
        S_WR_HI: begin
          if (r_cnt != c_LAST_MSG) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory outputs depend only on registered state, so reset clears them at once.
  always_comb begin
    w_state_nxt = r_state;
    Done        = 1'b0;
    mem_addr    = 10'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_RD_LO;
        end
      end
      S_RD_LO: begin
        mem_rd_en   = 1'b1;
        mem_addr    = c_SRC_BASE + w_msg_off;
        w_state_nxt = S_RD_HI;
      end
      S_RD_HI: begin
        mem_rd_en   = 1'b1;
        mem_addr    = c_SRC_BASE + w_msg_off + 10'd1;
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        w_state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = c_DST_BASE + w_msg_off;
        mem_wr_data = W'(r_cw_lo);
        w_state_nxt = S_WR_HI;
      end
      S_WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = c_DST_BASE + w_msg_off + 10'd1;
        mem_wr_data = W'(r_cw_hi);
        w_state_nxt = (r_cnt == c_LAST_MSG) ? S_DONE : S_RD_LO;
      end
      S_DONE: begin
        Done = 1'b1;
        if (!Start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_encoder.sv
`default_nettype none
// ============================================================================
// tb_hamming_secded_encoder : scoreboard bench with positional Hamming model
// Revision 1.0
// ============================================================================
module tb_hamming_secded_encoder;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Done;
  logic [9:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data = 8'd0;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [1024];
  logic [7:0] img [1024];
  logic [7:0] msg_lo [NUM_MSG];
  logic [7:0] msg_hi [NUM_MSG];
  wr_t        q [$];
  int         n_vec = 0;
  int         n_err = 0;

  hamming_secded_encoder #(
    .W(8), .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Codeword positions 1..15 as in textbook Hamming; position 0 holds overall parity.
  function automatic logic [15:0] ref_cw(input logic [7:0] lo, input logic [7:0] hi);
    logic [10:0] d;
    logic [15:0] cw;
    logic        x;
    int          k;
    d  = {hi[2:0], lo};
    cw = 16'd0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      x = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if (((pos >> p) & 1) == 1) x = x ^ cw[pos];
      end
      cw[1 << p] = x;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  always @(negedge Clk) begin
    wr_t e;
    if (!Reset) begin
      check("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
      if (mem_wr_en) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wr_data);
        end else begin
          e = q.pop_front();
          check("wr_addr", {22'd0, mem_addr}, {22'd0, e.a});
          check("wr_data", {24'd0, mem_wr_data}, {24'd0, e.d});
        end
      end
    end
  end

  task automatic load_msgs();
    for (int i = 0; i < NUM_MSG; i++) begin
      mem[(SRC_BASE + 2*i) % 1024]     = msg_lo[i];
      mem[(SRC_BASE + 2*i + 1) % 1024] = msg_hi[i];
      img[(SRC_BASE + 2*i) % 1024]     = msg_lo[i];
      img[(SRC_BASE + 2*i + 1) % 1024] = msg_hi[i];
    end
  endtask

  task automatic expect_msgs(input int n);
    logic [15:0] cw;
    wr_t         e;
    for (int i = 0; i < n; i++) begin
      cw  = ref_cw(msg_lo[i], msg_hi[i]);
      e.a = 10'((DST_BASE + 2*i) % 1024);
      e.d = cw[7:0];
      q.push_back(e);
      img[e.a] = e.d;
      e.a = 10'((DST_BASE + 2*i + 1) % 1024);
      e.d = cw[15:8];
      q.push_back(e);
      img[e.a] = e.d;
    end
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== img[a]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_full();
    int cyc;
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    cyc = 0;
    do begin
      @(posedge Clk);
      cyc++;
      #1;
    end while (!Done && cyc < 5*NUM_MSG + 20);
    check("done_latency", cyc, 5*NUM_MSG);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir_exp [10];
    dir_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h17, 8'h81, 8'h00, 8'h00};

    Reset = 1'b1;
    Start = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 8'($urandom);
      img[a] = mem[a];
    end
    repeat (2) @(posedge Clk);
    #1;
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    @(negedge Clk) Reset = 1'b0;

    // Run 1: directed corner messages followed by random ones.
    msg_lo[0] = 8'h00; msg_hi[0] = 8'h00;
    msg_lo[1] = 8'hFF; msg_hi[1] = 8'h07;
    msg_lo[2] = 8'h01; msg_hi[2] = 8'h00;
    msg_lo[3] = 8'h00; msg_hi[3] = 8'h04;
    msg_lo[4] = 8'h00; msg_hi[4] = 8'hF8;
    for (int i = 5; i < NUM_MSG; i++) begin
      msg_lo[i] = 8'($urandom);
      msg_hi[i] = 8'($urandom);
    end
    load_msgs();
    expect_msgs(NUM_MSG);
    run_full();
    repeat (20) @(posedge Clk);
    #1;
    check("done_held_start", {31'd0, Done}, 32'd1);
    check("run1_queue_drained", q.size(), 0);
    @(negedge Clk) Start = 1'b0;
    @(posedge Clk);
    #1;
    check("idle_after_start_low", {31'd0, Done}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("directed_byte_%0d", k), {24'd0, mem[DST_BASE + k]}, {24'd0, dir_exp[k]});
    end
    check_image("run1_image");

    // Run 2: reset asserted during WR_LO of message 3.
    for (int i = 0; i < NUM_MSG; i++) begin
      msg_lo[i] = 8'($urandom);
      msg_hi[i] = 8'($urandom);
    end
    load_msgs();
    expect_msgs(3);
    @(negedge Clk) Start = 1'b1;
    @(posedge Clk);
    repeat (18) @(posedge Clk);
    #1;
    check("wr_lo_msg3_en", {31'd0, mem_wr_en}, 32'd1);
    check("wr_lo_msg3_addr", {22'd0, mem_addr}, DST_BASE + 6);
    Reset = 1'b1;
    #1;
    check("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("midrst_addr", {22'd0, mem_addr}, 32'd0);
    check("midrst_done", {31'd0, Done}, 32'd0);
    Start = 1'b0;
    @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("idle_no_read", {31'd0, mem_rd_en | mem_wr_en}, 32'd0);
    check("run2_queue_drained", q.size(), 0);
    check_image("run2_image");

    // Run 3: clean re-encode of the same messages from message 0.
    expect_msgs(NUM_MSG);
    run_full();
    @(negedge Clk) Start = 1'b0;
    @(posedge Clk);
    #1;
    check("run3_queue_drained", q.size(), 0);
    check_image("run3_image");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
